// File: rtl/fix_to_fp_11_4.sv
// Fixed-point to FP_11_4 encoder: iterative normalisation (one shift per cycle),
// round-to-nearest-even packing, valid/ready handshake on both sides.
module fix_to_fp_11_4 #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned IN_FRAC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [17:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int unsigned SW    = $clog2(IN_W);
  // Exponent of a magnitude whose MSB sits at bit IN_W-1 after s shifts is EBase - s.
  localparam int          EBase = int'(IN_W) - int'(IN_FRAC) + 6;

  typedef enum logic [1:0] {StIdle, StNorm, StPack, StHold} state_e;

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [IN_W-1:0] mag_q, mag_d;
  logic [SW-1:0]   s_q, s_d;
  logic            zero_q, zero_d;
  logic [17:0]     out_data_q, out_data_d;

  logic [10:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [11:0] frac_sum;
  logic [10:0] frac_out;
  logic [6:0]  exp_raw;
  logic [6:0]  exp_rnd;
  logic [17:0] pack_word;

  // Round the normalised magnitude and form the FP_11_4 word (7-bit two's-complement exponent).
  always_comb begin
    frac      = mag_q[IN_W-2 -: 11];
    guard     = mag_q[IN_W-13];
    sticky    = |mag_q[IN_W-14:0];
    round_up  = guard & (sticky | frac[0]);
    frac_sum  = {1'b0, frac} + 12'(round_up);
    frac_out  = frac_sum[11] ? 11'd0 : frac_sum[10:0];
    exp_raw   = 7'(EBase) - 7'(s_q);
    exp_rnd   = exp_raw + 7'(frac_sum[11]);
    pack_word = 18'd0;
    if (zero_q || exp_rnd[6]) begin
      pack_word = 18'd0;
    end else if (exp_rnd[5:4] != 2'b00) begin
      pack_word = {2'b10, sign_q, 15'd0};
    end else begin
      pack_word = {2'b01, sign_q, exp_rnd[3:0], frac_out};
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    s_d        = s_q;
    zero_d     = zero_q;
    out_data_d = out_data_q;
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StHold);
    out_data   = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = in_data[IN_W-1];
          // Most negative input maps to itself, which is its correct unsigned magnitude.
          mag_d   = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
          s_d     = '0;
          zero_d  = 1'b0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          state_d = StPack;
        end else if (!mag_q[IN_W-1]) begin
          mag_d = mag_q << 1;
          s_d   = s_q + SW'(1);
        end else begin
          state_d = StPack;
        end
      end
      StPack: begin
        out_data_d = pack_word;
        state_d    = StHold;
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      s_q        <= '0;
      zero_q     <= 1'b0;
      out_data_q <= 18'd0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      s_q        <= s_d;
      zero_q     <= zero_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fix_to_fp_11_4.sv
// Directed scoreboard bench for fix_to_fp_11_4.
module tb_fix_to_fp_11_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [17:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fix_to_fp_11_4 #(.IN_W(16), .IN_FRAC(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operand in IDLE; it is accepted at the following rising edge.
  task automatic start(input logic [15:0] d, input logic [17:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    e.data = exp;
    e.lat  = lat;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // Wait (bounded) for out_valid, then compare against the scoreboard head.
  task automatic wait_result();
    int   n;
    logic ir_bad;
    exp_t e;
    n      = 0;
    ir_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (in_ready) ir_bad = 1'b1;
    end while (!out_valid && n < 40);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("out_valid_seen", 32'(out_valid), 32'd1);
      check("latency", 32'(n - 1), 32'(e.lat));
      check("out_data", 32'(out_data), 32'(e.data));
      check("in_ready_busy", 32'(ir_bad), 32'd0);
    end
  endtask

  task automatic release_check();
    @(negedge clk);
    check("released_valid", 32'(out_valid), 32'd0);
    check("released_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_conv(input logic [15:0] d, input logic [17:0] exp, input int lat);
    out_ready = 1'b1;
    start(d, exp, lat);
    wait_result();
    release_check();
  endtask

  logic [15:0] vec_in  [10] = '{16'h0100, 16'hFF00, 16'h8000, 16'h0000, 16'h7FFF,
                                16'h1001, 16'h1003, 16'h0101, 16'h0001, 16'h0080};
  logic [17:0] vec_exp [10] = '{18'h13800, 18'h1B800, 18'h1F000, 18'h00000, 18'h17000,
                                18'h15800, 18'h15802, 18'h13808, 18'h00000, 18'h13000};
  int          vec_lat [10] = '{9, 9, 2, 2, 3, 5, 5, 9, 17, 10};

  initial begin
    exp_t dummy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_conv(vec_in[i], vec_exp[i], vec_lat[i]);

    // Backpressure: result held, a second operand is ignored while holding.
    out_ready = 1'b0;
    start(16'h0100, 18'h13800, 9);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0080;
      @(negedge clk);
      check("hold_data", 32'(out_data), 32'h13800);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    release_check();
    do_conv(16'h0080, 18'h13000, 10);

    // Reset during normalisation aborts the conversion.
    start(16'h0001, 18'h00000, 17);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_data", 32'(out_data), 32'd0);
    if (sb.size() > 0) dummy = sb.pop_back();
    rst_n = 1'b1;
    do_conv(16'h0100, 18'h13800, 9);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fix_to_fp_11_4.md
Name: fix_to_fp_11_4

Overview:
- Sequential encoder from signed two's-complement fixed-point to the 18-bit FP_11_4 word consumed by the comparator and adder datapath.
- FP_11_4 word layout: [17:16] exception (00 zero, 01 normal, 10 inf, 11 NaN), [15] sign, [14:11] exponent (bias 7), [10:0] fraction.
- Normalisation is iterative, one left shift per cycle. The block sits on the front end of the ray/box datapath and feeds ray and box coordinates into the FP pipeline.
- Valid/ready handshake on both sides.

Parameters:
- IN_W, 16: input width; the module is only required to work at 16.
- IN_FRAC, 8: number of fractional bits in the input; input value = in_data / 2^IN_FRAC.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  IN_W  signed fixed-point operand
- in_valid  in  1  operand present
- in_ready  out  1  encoder can accept an operand
- out_data  out  18  FP_11_4 result
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at a rising edge): state IDLE, in_ready=1, out_valid=0, out_data=0, internal registers cleared.
- Reset mid-operation aborts the current conversion; no output is produced for it.
- FSM states: IDLE, NORM, PACK, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch sign=in_data[IN_W-1], mag=|in_data| as 16-bit unsigned (0x8000 gives 0x8000), s=0, then go to NORM.
  - in_ready=0 in every other state.
- NORM:
  - If mag==0: go to PACK with the zero flag set.
  - Else if mag[15]==0: mag<<=1, s+=1, stay in NORM.
  - Else go to PACK.
  - At most 15 shifts.
- PACK:
  - e = IN_W - IN_FRAC + 6 - s, signed, computed at least 6 bits wide.
  - Fraction f = mag[14:4], guard = mag[3], sticky = |mag[2:0].
  - Round to nearest, ties to even: increment f if guard & (sticky | f[0]).
  - If f overflows: f=0, e+=1.
  - Zero flag, or e<0 after rounding: out_data = 18'h00000 (exception 00, sign 0).
  - e>15: out_data = {2'b10, sign, 15'b0}.
  - Otherwise: out_data = {2'b01, sign, e[3:0], f}.
  - Set out_valid=1 and go to HOLD.
- HOLD:
  - out_valid=1; out_data held stable.
  - On out_ready: out_valid=0, go to IDLE.
  - No new operand is accepted in the cycle of release; the next acceptance is at the following edge.
- Latency: an operand accepted at edge k needing s shifts gives out_valid high after edge k+s+2. Zero input gives latency 2; worst case is 17.
- Throughput: one conversion in flight at a time.
- Output NaN is never produced.
- in_data and in_valid changes outside IDLE are ignored.

Test Plan:
- in_data=0x0100 (1.0), out_ready=1 -> out_data=0x13800 after edge k+9, in_ready low throughout conversion.
- in_data=0xFF00 (-1.0) -> 0x1B800. in_data=0x8000 (-128) -> 0x1F000 with latency 2. in_data=0x0000 -> 0x00000 with latency 2.
- Rounding:
  - 0x7FFF -> 0x17000 (round-up carry into exponent).
  - 0x1001 -> 0x15800 (tie, stays even).
  - 0x1003 -> 0x15802 (tie, rounds up to even).
  - 0x0101 -> 0x13808 (exact).
- Underflow: in_data=0x0001 -> 0x00000 after edge k+17. in_data=0x0080 (0.5) -> 0x13000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, second in_valid ignored. Raise out_ready -> release, then next operand accepted one cycle later and converted correctly.
- Reset: drop rst_n during NORM of 0x0001 -> next edge out_valid=0, in_ready=1, out_data=0; a subsequent 0x0100 yields 0x13800.
